// File: rtl/sm_regdump_if.sv
// sm_regdump_if -- debug-port and byte-stream bundle for sm_regdump.
//   regAddr   : debug register address driven by the dumper
//   regData   : register contents, combinational from regAddr
//   out_data  : byte stream data
//   out_valid : out_data holds a byte
//   out_ready : sink accepts the byte (transfer = out_valid & out_ready)
// Modports: master = dumper side, slave = CPU debug port / stream sink side.
interface sm_regdump_if;
  logic [4:0]  regAddr;
  logic [31:0] regData;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output regAddr,
    input  regData,
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  regAddr,
    output regData,
    input  out_data,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/sm_regdump.sv
// sm_regdump -- walks debug registers FIRST_REG..LAST_REG and streams each
// one out as a byte record, most significant byte first.
//   clk   : single clock, rising edge
//   rst   : synchronous active-high reset
//   start : dump request, only honoured while idle
//   busy  : high whenever a dump is in progress (any state but idle)
//   done  : one-cycle pulse after the last byte of the dump is accepted
//   bus   : sm_regdump_if.master (regAddr/regData debug port, byte stream)
// Build option: define SM_REGDUMP_HEADER_EN to prefix every record with a
// header byte {3'b000, regAddr} (5-byte records instead of 4).
module sm_regdump #(
  parameter int unsigned FIRST_REG = 0,
  parameter int unsigned LAST_REG  = 31
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  sm_regdump_if.master        bus,
  output logic                busy,
  output logic                done
);

`ifdef SM_REGDUMP_HEADER_EN
  localparam int unsigned NBYTES = 5;
`else
  localparam int unsigned NBYTES = 4;
`endif

  localparam logic [2:0] LAST_IDX   = 3'(NBYTES - 1);
  localparam logic [4:0] FIRST_ADDR = 5'(FIRST_REG);
  localparam logic [4:0] LAST_ADDR  = 5'(LAST_REG);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_DONE
  } state_t;

  state_t      r_state;
  logic [4:0]  r_addr;
  logic [31:0] r_word;
  logic [2:0]  r_idx;
  logic [7:0]  r_data;
  logic        r_valid;
  logic        r_busy;
  logic        r_done;

`ifdef SM_REGDUMP_HEADER_EN
  // Index 0 is the header byte; indices 1..4 walk the word MSB first.
  function automatic logic [7:0] pick_byte(input logic [31:0] word,
                                           input logic [4:0]  addr,
                                           input logic [2:0]  idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = {3'b000, addr};
      3'd1:    b = word[31:24];
      3'd2:    b = word[23:16];
      3'd3:    b = word[15:8];
      default: b = word[7:0];
    endcase
    return b;
  endfunction
`else
  function automatic logic [7:0] pick_byte(input logic [31:0] word,
                                           input logic [2:0]  idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = word[31:24];
      3'd1:    b = word[23:16];
      3'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    return b;
  endfunction
`endif

  // out_data is registered, so the first byte of a record is chosen from
  // regData in LOAD and each following byte is chosen as the index advances.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_word  <= '0;
      r_idx   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_addr  <= FIRST_ADDR;
            r_busy  <= 1'b1;
            r_state <= S_LOAD;
          end
        end

        S_LOAD: begin
          r_word  <= bus.regData;
          r_idx   <= '0;
`ifdef SM_REGDUMP_HEADER_EN
          r_data  <= pick_byte(bus.regData, r_addr, 3'd0);
`else
          r_data  <= pick_byte(bus.regData, 3'd0);
`endif
          r_valid <= 1'b1;
          r_state <= S_SEND;
        end

        S_SEND: begin
          if (bus.out_ready) begin
            if (r_idx == LAST_IDX) begin
              r_valid <= 1'b0;
              if (r_addr == LAST_ADDR) begin
                r_done  <= 1'b1;
                r_state <= S_DONE;
              end else begin
                r_addr  <= r_addr + 5'd1;
                r_state <= S_LOAD;
              end
            end else begin
              r_idx  <= r_idx + 3'd1;
`ifdef SM_REGDUMP_HEADER_EN
              r_data <= pick_byte(r_word, r_addr, r_idx + 3'd1);
`else
              r_data <= pick_byte(r_word, r_idx + 3'd1);
`endif
            end
          end
        end

        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.regAddr   = r_addr;
  assign bus.out_data  = r_data;
  assign bus.out_valid = r_valid;
  assign busy          = r_busy;
  assign done          = r_done;

endmodule

// File: tb/tb_sm_regdump.sv
module tb_sm_regdump;

`ifdef SM_REGDUMP_HEADER_EN
  localparam int NB = 5;
`else
  localparam int NB = 4;
`endif

  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_a = 1'b0;
  logic start_b = 1'b0;
  logic busy_a, done_a, busy_b, done_b;

  logic [31:0] regs_a [32];
  logic [31:0] regs_b [32];

  sm_regdump_if bus_a ();
  sm_regdump_if bus_b ();

  assign bus_a.regData = regs_a[bus_a.regAddr];
  assign bus_b.regData = regs_b[bus_b.regAddr];

  sm_regdump #(.FIRST_REG(2), .LAST_REG(3)) u_dut_a (
    .clk   (clk),
    .rst   (rst),
    .start (start_a),
    .bus   (bus_a),
    .busy  (busy_a),
    .done  (done_a)
  );

  sm_regdump u_dut_b (
    .clk   (clk),
    .rst   (rst),
    .start (start_b),
    .bus   (bus_b),
    .busy  (busy_b),
    .done  (done_b)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Stream monitors: sampled on the falling edge, inputs change just after the rising edge.
  bq_t  obs_a, obs_b;
  int   done_cnt_a = 0, done_cnt_b = 0;
  int   busy_cyc_a = 0, busy_cyc_b = 0;
  logic stall_a = 1'b0, stall_b = 1'b0;
  logic [7:0] hold_a = '0, hold_b = '0;

  always @(negedge clk) begin
    if (stall_a) begin
      check("a_hold_valid", 32'(bus_a.out_valid), 32'd1);
      check("a_hold_data", 32'(bus_a.out_data), 32'(hold_a));
    end
    stall_a <= !rst && bus_a.out_valid && !bus_a.out_ready;
    hold_a  <= bus_a.out_data;
    if (!rst && bus_a.out_valid && bus_a.out_ready) obs_a.push_back(bus_a.out_data);
    if (done_a) done_cnt_a <= done_cnt_a + 1;
    if (busy_a) busy_cyc_a <= busy_cyc_a + 1;
  end

  always @(negedge clk) begin
    if (stall_b) begin
      check("b_hold_valid", 32'(bus_b.out_valid), 32'd1);
      check("b_hold_data", 32'(bus_b.out_data), 32'(hold_b));
    end
    stall_b <= !rst && bus_b.out_valid && !bus_b.out_ready;
    hold_b  <= bus_b.out_data;
    if (!rst && bus_b.out_valid && bus_b.out_ready) obs_b.push_back(bus_b.out_data);
    if (done_b) done_cnt_b <= done_cnt_b + 1;
    if (busy_b) busy_cyc_b <= busy_cyc_b + 1;
  end

  // Reference: a dump is the concatenation of records, one per register.
  function automatic void model_dump(input int first, input int last,
                                     input logic [31:0] rf [32], output bq_t q);
    q = {};
    for (int r = first; r <= last; r++) begin
      if (NB == 5) q.push_back(8'(r));
      for (int b = 3; b >= 0; b--) q.push_back(8'(rf[r] >> (8 * b)));
    end
  endfunction

  task automatic compare(input string tag, input bq_t got, input int base, input bq_t exp);
    check($sformatf("%s_len", tag), 32'(got.size() - base), 32'(exp.size()));
    for (int i = 0; i < exp.size(); i++)
      if (base + i < got.size())
        check($sformatf("%s_byte%0d", tag, i), 32'(got[base + i]), 32'(exp[i]));
  endtask

  task automatic set_ready(input bit b, input int unsigned pct);
    logic r;
    r = ($urandom_range(99) < pct);
    if (b) bus_b.out_ready = r;
    else   bus_a.out_ready = r;
  endtask

  task automatic run_dump(input bit b, input int unsigned pct, output int cyc);
    int d0, bc0;
    d0  = b ? done_cnt_b : done_cnt_a;
    bc0 = b ? busy_cyc_b : busy_cyc_a;
    set_ready(b, pct);
    if (b) start_b = 1'b1;
    else   start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    start_b = 1'b0;
    for (int k = 0; k < 5000; k++) begin
      if ((b ? done_cnt_b : done_cnt_a) != d0) break;
      set_ready(b, pct);
      @(posedge clk); #1;
    end
    if (b) check("b_done_pulse", 32'(done_cnt_b - d0), 32'd1);
    else   check("a_done_pulse", 32'(done_cnt_a - d0), 32'd1);
    cyc = (b ? busy_cyc_b : busy_cyc_a) - bc0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t exp, exp2;
    int  base, cyc, d0;
    logic [31:0] snap [32];

    bus_a.out_ready = 1'b0;
    bus_b.out_ready = 1'b0;
    for (int i = 0; i < 32; i++) begin
      regs_a[i] = $urandom;
      regs_b[i] = $urandom;
    end

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_valid", 32'(bus_a.out_valid), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    check("rst_addr", 32'(bus_a.regAddr), 32'd0);
    check("rst_data", 32'(bus_a.out_data), 32'd0);
    check("rst_b_addr", 32'(bus_b.regAddr), 32'd0);
    check("rst_b_valid", 32'(bus_b.out_valid), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Two-register dump, sink always ready: exact bytes and timing
    regs_a[2] = 32'h11223344;
    regs_a[3] = 32'hAABBCCDD;
    base = obs_a.size();
    run_dump(1'b0, 100, cyc);
    model_dump(2, 3, regs_a, exp);
    compare("basic", obs_a, base, exp);
    check("basic_cycles", 32'(cyc), 32'(2 * (NB + 1) + 1));
    check("basic_addr_end", 32'(bus_a.regAddr), 32'd3);
    check("basic_idle", 32'(busy_a), 32'd0);

    // Random contents with random back-pressure
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 32; i++) regs_a[i] = $urandom;
      base = obs_a.size();
      run_dump(1'b0, 30 + 10 * t, cyc);
      model_dump(2, 3, regs_a, exp);
      compare($sformatf("rnd%0d", t), obs_a, base, exp);
      check($sformatf("rnd%0d_addr", t), 32'(bus_a.regAddr), 32'd3);
    end

    // Five-cycle stall while 0x22 is presented
    regs_a[2] = 32'h11223344;
    regs_a[3] = 32'hAABBCCDD;
    base = obs_a.size();
    d0 = done_cnt_a;
    bus_a.out_ready = 1'b1;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (bus_a.out_valid && bus_a.out_data == 8'h22) break;
      @(posedge clk); #1;
    end
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", 32'(bus_a.out_valid), 32'd1);
      check("stall_data", 32'(bus_a.out_data), 32'h22);
      bus_a.out_ready = 1'b0;
      @(posedge clk); #1;
    end
    check("stall_data_end", 32'(bus_a.out_data), 32'h22);
    bus_a.out_ready = 1'b1;
    for (int k = 0; k < 50 && done_cnt_a == d0; k++) begin
      @(posedge clk); #1;
    end
    check("stall_done", 32'(done_cnt_a - d0), 32'd1);
    model_dump(2, 3, regs_a, exp);
    compare("stall", obs_a, base, exp);

    // Reset in the middle of the second record
    d0 = done_cnt_a;
    bus_a.out_ready = 1'b1;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (bus_a.regAddr == 5'd3 && bus_a.out_valid) break;
      @(posedge clk); #1;
    end
    check("abort_reached", 32'(bus_a.regAddr), 32'd3);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_valid", 32'(bus_a.out_valid), 32'd0);
    check("abort_busy", 32'(busy_a), 32'd0);
    check("abort_addr", 32'(bus_a.regAddr), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    check("abort_no_done", 32'(done_cnt_a - d0), 32'd0);
    check("abort_stay_idle", 32'(busy_a), 32'd0);
    for (int i = 0; i < 32; i++) regs_a[i] = $urandom;
    base = obs_a.size();
    run_dump(1'b0, 70, cyc);
    model_dump(2, 3, regs_a, exp);
    compare("restart", obs_a, base, exp);

    // start held high; register changes after capture must not leak
    for (int i = 0; i < 32; i++) regs_a[i] = $urandom;
    snap = regs_a;
    model_dump(2, 3, snap, exp);
    base = obs_a.size();
    d0 = done_cnt_a;
    bus_a.out_ready = 1'b1;
    start_a = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (bus_a.out_valid) break;
    end
    regs_a[2] = ~regs_a[2];
    for (int k = 0; k < 50 && done_cnt_a == d0; k++) begin
      @(posedge clk); #1;
    end
    check("held_one_done", 32'(done_cnt_a - d0), 32'd1);
    compare("held_snap", obs_a, base, exp);
    check("held_idle", 32'(busy_a), 32'd0);
    @(posedge clk); #1;
    check("held_restart", 32'(busy_a), 32'd1);
    start_a = 1'b0;
    base = base + exp.size();
    model_dump(2, 3, regs_a, exp2);
    for (int k = 0; k < 50 && done_cnt_a == d0 + 1; k++) begin
      @(posedge clk); #1;
    end
    check("held_second_done", 32'(done_cnt_a - d0), 32'd2);
    compare("held_second", obs_a, base, exp2);

    // Default range: PC first, all 32 registers
    regs_b[0] = 32'h00000040;
    base = obs_b.size();
    run_dump(1'b1, 100, cyc);
    model_dump(0, 31, regs_b, exp);
    compare("dflt", obs_b, base, exp);
    check("dflt_cycles", 32'(cyc), 32'(32 * (NB + 1) + 1));
    check("dflt_addr_end", 32'(bus_b.regAddr), 32'd31);

    for (int i = 0; i < 32; i++) regs_b[i] = $urandom;
    base = obs_b.size();
    run_dump(1'b1, 60, cyc);
    model_dump(0, 31, regs_b, exp);
    compare("dflt_rnd", obs_b, base, exp);
    check("dflt_rnd_addr", 32'(bus_b.regAddr), 32'd31);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sm_regdump.md
SM_REGDUMP -- requirements
Module: sm_regdump

Interface
REQ-001 SHALL have parameter FIRST_REG, default 0, first debug register index dumped (0 reads PC).
REQ-002 SHALL have parameter LAST_REG, default 31, last debug register index dumped; FIRST_REG <= LAST_REG <= 31.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-005 SHALL have port start  input  1  dump request, sampled only in IDLE.
REQ-006 SHALL have port regAddr  output  5  debug register address driven to the CPU debug port.
REQ-007 SHALL have port regData  input  32  debug register data, combinational from regAddr.
REQ-008 SHALL have port out_data  output  8  byte stream data.
REQ-009 SHALL have port out_valid  output  1  out_data holds a byte.
REQ-010 SHALL have port out_ready  input  1  sink accepts the byte; transfer = out_valid & out_ready on a clock edge.
REQ-011 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-012 SHALL have port done  output  1  one-cycle pulse after the final byte of the dump is accepted.

Function
REQ-013 SHALL implement states IDLE, LOAD, SEND, DONE as a registered FSM.
REQ-014 IDLE: start=1 -> regAddr<=FIRST_REG, go to LOAD; start while not IDLE SHALL be ignored.
REQ-015 LOAD (one cycle, regAddr stable for the whole cycle): capture regData into a 32-bit word register, clear the byte index, go to SEND.
REQ-016 SEND: out_valid=1; out_data = word byte selected by the index, most significant byte first (bits 31:24, 23:16, 15:8, 7:0).
REQ-017 out_data and out_valid SHALL stay stable while out_valid=1 and out_ready=0; no byte is dropped or repeated.
REQ-018 On transfer of a non-final byte of a record, the index SHALL increment, with the next byte valid in the following cycle.
REQ-019 On transfer of the final byte of a record: if regAddr==LAST_REG go to DONE, else regAddr<=regAddr+1 and go to LOAD.
REQ-020 DONE: done=1 for exactly one cycle, then IDLE; regAddr keeps its last value.
REQ-021 out_valid SHALL be 0 in IDLE, LOAD and DONE, so each record has a one-cycle bubble.
REQ-022 The captured word SHALL be the LOAD-cycle snapshot; later regData changes do not affect bytes in flight.
REQ-023 With out_ready held 1, a record (N bytes) SHALL take N+1 cycles; a full dump SHALL take R*(N+1)+1 cycles from leaving IDLE to returning to IDLE, where R = LAST_REG-FIRST_REG+1.
REQ-024 FIRST_REG==LAST_REG SHALL dump exactly one record.
REQ-025 regAddr SHALL never exceed LAST_REG; no wrap from 31 to 0.

Reset
REQ-026 rst=1 at a clock edge SHALL force IDLE, regAddr=0, word=0, index=0, out_valid=0, busy=0, done=0, out_data=0, taking priority over all other inputs.
REQ-027 rst asserted mid-dump SHALL abort it with no done pulse; the next start restarts at FIRST_REG.

Configuration
REQ-028 Macro SM_REGDUMP_HEADER_EN SHALL compile in a per-record header byte.
REQ-029 With SM_REGDUMP_HEADER_EN defined: each record SHALL be 5 bytes, header {3'b000, regAddr} first, then the 4 data bytes MSB first (N=5).
REQ-030 Without SM_REGDUMP_HEADER_EN: each record SHALL be 4 data bytes only (N=4), and no header logic is present.

Verification
REQ-031 FIRST_REG=2, LAST_REG=3, r2=0x11223344, r3=0xAABBCCDD, out_ready=1, no header: start pulse -> bytes 11 22 33 44 AA BB CC DD, then done one cycle, 11 cycles from leaving IDLE to IDLE.
REQ-032 Same setup with SM_REGDUMP_HEADER_EN: bytes 02 11 22 33 44 03 AA BB CC DD.
REQ-033 out_ready=0 for 5 cycles while byte 0x22 is presented: out_data=0x22 and out_valid=1 held all 5 cycles; the stream continues with 0x33 and nothing is lost.
REQ-034 rst=1 during the second record: next cycle out_valid=0, busy=0, regAddr=0, no done pulse; a new start emits the FIRST_REG record first.
REQ-035 start held high for the whole dump, with regData for the current register changed after LOAD: exactly one dump, snapshot bytes emitted, and a new dump begins only after done when start is still 1 in IDLE.
REQ-036 Defaults FIRST_REG=0, LAST_REG=31, PC=0x00000040: first record is 00 00 00 40, 32 records total, regAddr ends at 31.
